// File: rtl/shot_pkg.sv
// shot_pkg: shared types and constants for the shot-clock annunciator.
//   horn_state_t  : horn sequencer states (IDLE / HORN / CHIRP)
//   SEG_*         : active-high seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   TENS_ONE      : the only pattern the tens digit ever shows
package shot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HORN  = 2'd1,
    CHIRP = 2'd2
  } horn_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;

  localparam logic [6:0] TENS_ONE  = SEG_1;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD digit to active-high seven-segment pattern.
//   digit : 4-bit value; 0..9 decode to a numeral, 10..15 decode blank
//   seg   : segments {g,f,e,d,c,b,a}, 1 = lit
module seg7_decode
  import shot_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/shot_annunciator.sv
// shot_annunciator: turns the shot-clock counter outputs into a two-digit
// seven-segment display (blinking near expiry) and a horn sequence
// (long blast on buzz, short chirp on shoot).
//
// Ports
//   clk      : system clock, rising edge
//   nrst     : synchronous reset, active-high (1 = reset on next edge)
//   count    : remaining shot-clock value 0..15
//   shoot    : shot-event level
//   buzz     : expiry level
//   seg_tens : tens digit segments {g,f,e,d,c,b,a}
//   seg_ones : ones digit segments {g,f,e,d,c,b,a}
//   horn     : horn drive, 1 = sounding
//
// Build option
//   ANNUNC_ACTIVE_LOW_SEG_EN : when defined, both segment outputs are
//   inverted at the output register for common-anode displays (reset and
//   blank become 7'h7F). The horn is unaffected.
module shot_annunciator
  import shot_pkg::*;
#(
  parameter int HORN_CYCLES  = 8,
  parameter int CHIRP_CYCLES = 2,
  parameter int BLINK_DIV    = 4,
  parameter int WARN_LEVEL   = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] count,
  input  logic       shoot,
  input  logic       buzz,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       horn
);

  localparam int TMR_W = $clog2(HORN_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);

  localparam logic [TMR_W-1:0] HORN_LOAD  = TMR_W'(HORN_CYCLES - 1);
  localparam logic [TMR_W-1:0] CHIRP_LOAD = TMR_W'(CHIRP_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

`ifdef ANNUNC_ACTIVE_LOW_SEG_EN
  localparam logic [6:0] SEG_POL = 7'h7F;
`else
  localparam logic [6:0] SEG_POL = 7'h00;
`endif

  // ---------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------
  logic buzz_q, shoot_q;
  logic buzz_rise, shoot_rise;

  // The history registers keep following the inputs through reset, so a
  // level that is already high when reset releases is not mistaken for a
  // fresh edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    buzz_q  <= buzz;
    shoot_q <= shoot;
  end

  assign buzz_rise  = buzz  & ~buzz_q;
  assign shoot_rise = shoot & ~shoot_q;

  // ---------------------------------------------------------------------
  // Horn sequencer
  // ---------------------------------------------------------------------
  horn_state_t      state, next_state;
  logic [TMR_W-1:0] tmr, next_tmr;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-high here; it is only seen
    // on a clock edge, so nrst is deliberately absent from the
    // sensitivity list.
    if (nrst) begin
      state <= IDLE;
      tmr   <= '0;
      horn  <= 1'b0;
    end else begin
      state <= next_state;
      tmr   <= next_tmr;
      // horn lags the state by one register, giving the two-edge latency
      // from the input change while keeping the on-time equal to the
      // number of cycles spent in HORN/CHIRP.
      horn  <= (state != IDLE);
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no
    // latch is inferred.
    next_state = state;
    next_tmr   = tmr;
    unique case (state)
      IDLE: begin
        // buzz is checked first so a simultaneous shoot edge is dropped.
        if (buzz_rise) begin
          next_state = HORN;
          next_tmr   = HORN_LOAD;
        end else if (shoot_rise) begin
          next_state = CHIRP;
          next_tmr   = CHIRP_LOAD;
        end
      end
      HORN: begin
        if (buzz_rise) begin
          next_tmr = HORN_LOAD;
        end else if (tmr == '0) begin
          next_state = IDLE;
        end else begin
          next_tmr = tmr - 1'b1;
        end
      end
      CHIRP: begin
        if (buzz_rise) begin
          next_state = HORN;
          next_tmr   = HORN_LOAD;
        end else if (tmr == '0) begin
          next_state = IDLE;
        end else begin
          next_tmr = tmr - 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_tmr   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Display
  // ---------------------------------------------------------------------
  logic             is_teen, in_warn;
  logic [3:0]       tens_digit, ones_digit;
  logic [6:0]       tens_seg, ones_seg;
  logic [6:0]       next_tens, next_ones;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;

  assign is_teen    = (count >= 4'd10);
  assign in_warn    = (count != 4'd0) && (int'(count) <= WARN_LEVEL);
  assign tens_digit = {3'b000, is_teen};
  assign ones_digit = is_teen ? (count - 4'd10) : count;

  seg7_decode u_tens (
    .digit (tens_digit),
    .seg   (tens_seg)
  );

  seg7_decode u_ones (
    .digit (ones_digit),
    .seg   (ones_seg)
  );

  always_comb begin
    // A decoded tens digit of zero is the leading zero, shown blank.
    next_tens = (tens_seg == TENS_ONE) ? tens_seg : SEG_BLANK;
    next_ones = ones_seg;
    if (in_warn && !blink_on) begin
      next_tens = SEG_BLANK;
      next_ones = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      seg_tens  <= SEG_BLANK ^ SEG_POL;
      seg_ones  <= SEG_BLANK ^ SEG_POL;
    end else begin
      // Outside the warning range the blinker is parked lit at count 0,
      // so every entry into the range begins with a full lit half-period.
      if (!in_warn) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      seg_tens <= next_tens ^ SEG_POL;
      seg_ones <= next_ones ^ SEG_POL;
    end
  end

endmodule

// File: tb/tb_shot_annunciator.sv
// tb_shot_annunciator: directed self-checking bench for shot_annunciator.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the result of the edge just taken.
module tb_shot_annunciator;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] count;
  logic       shoot;
  logic       buzz;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic       horn;

  int checks   = 0;
  int failures = 0;

`ifdef ANNUNC_ACTIVE_LOW_SEG_EN
  localparam logic [6:0] POL = 7'h7F;
`else
  localparam logic [6:0] POL = 7'h00;
`endif

  localparam logic [6:0] D_BLANK = 7'b0000000;
  localparam logic [6:0] D0      = 7'b0111111;
  localparam logic [6:0] D1      = 7'b0000110;
  localparam logic [6:0] D2      = 7'b1011011;
  localparam logic [6:0] D3      = 7'b1001111;
  localparam logic [6:0] D5      = 7'b1101101;
  localparam logic [6:0] D9      = 7'b1101111;

  shot_annunciator #(
    .HORN_CYCLES  (8),
    .CHIRP_CYCLES (2),
    .BLINK_DIV    (4),
    .WARN_LEVEL   (3)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .count    (count),
    .shoot    (shoot),
    .buzz     (buzz),
    .seg_tens (seg_tens),
    .seg_ones (seg_ones),
    .horn     (horn)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_segs(input string tag, input logic [6:0] tens, input logic [6:0] ones);
    check({tag, "_tens"}, seg_tens, tens ^ POL);
    check({tag, "_ones"}, seg_ones, ones ^ POL);
  endtask

  task automatic check_horn(input string tag, input logic exp);
    check(tag, {6'b0, horn}, {6'b0, exp});
  endtask

  initial begin
    nrst  = 1'b1;
    count = 4'd12;
    shoot = 1'b0;
    buzz  = 1'b0;

    // Reset state
    tick();
    check_segs("reset", D_BLANK, D_BLANK);
    check_horn("reset_horn", 1'b0);

    // count=12 -> "12" one cycle later
    nrst = 1'b0;
    tick();
    check_segs("c12", D1, D2);
    check_horn("c12_horn", 1'b0);

    // Other digits: 0 steady, 9 with blank tens, 15, 10
    count = 4'd0;  tick(); check_segs("c0", D_BLANK, D0);
    tick();                check_segs("c0_steady", D_BLANK, D0);
    count = 4'd9;  tick(); check_segs("c9", D_BLANK, D9);
    count = 4'd15; tick(); check_segs("c15", D1, D5);
    count = 4'd10; tick(); check_segs("c10", D1, D0);

    // Blink: count=3 lit for 4 cycles, off 4, lit 4
    count = 4'd3;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k >= 5 && k <= 8) check_segs($sformatf("blink%0d", k), D_BLANK, D_BLANK);
      else                  check_segs($sformatf("blink%0d", k), D_BLANK, D3);
    end
    // Advance into an off phase, then leave the range: steady 5 next cycle
    for (int k = 13; k <= 16; k++) tick();
    check_segs("blink_off_again", D_BLANK, D_BLANK);
    count = 4'd5;  tick(); check_segs("leave_warn", D_BLANK, D5);
    // Re-entry starts lit
    count = 4'd2;  tick(); check_segs("reenter_lit", D_BLANK, D2);
    count = 4'd12;

    // Shoot pulse: horn on for exactly 2 cycles, starting 2 edges after rise
    shoot = 1'b1; tick(); check_horn("chirp_e1", 1'b0);
    shoot = 1'b0; tick(); check_horn("chirp_e2", 1'b1);
    tick();               check_horn("chirp_e3", 1'b1);
    tick();               check_horn("chirp_e4", 1'b0);
    tick();               check_horn("chirp_e5", 1'b0);

    // Buzz held 20 cycles: horn on for edges 2..9 only
    buzz = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_horn($sformatf("buzz_held_e%0d", k), (k >= 2 && k <= 9));
    end
    buzz = 1'b0;
    tick(); tick();

    // Shoot rise then buzz rise during the chirp: horn high edges 2..10
    shoot = 1'b1;
    tick(); check_horn("abort_e1", 1'b0);
    buzz = 1'b1;
    for (int k = 2; k <= 12; k++) begin
      tick();
      check_horn($sformatf("abort_e%0d", k), (k >= 2 && k <= 10));
    end
    shoot = 1'b0; buzz = 1'b0;
    tick(); tick();

    // Simultaneous rise: 8 cycles only
    shoot = 1'b1; buzz = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_horn($sformatf("simul_e%0d", k), (k >= 2 && k <= 9));
    end
    shoot = 1'b0; buzz = 1'b0;
    tick(); tick();

    // Reset on the 4th horn cycle, buzz held through release: no horn
    buzz = 1'b1;
    tick(); check_horn("rst_blast_e1", 1'b0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check_horn($sformatf("rst_blast_e%0d", k), 1'b1);
    end
    nrst = 1'b1;
    tick();
    check_horn("rst_mid_horn", 1'b0);
    check_segs("rst_mid_segs", D_BLANK, D_BLANK);
    nrst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_horn($sformatf("post_rst_e%0d", k), 1'b0);
    end
    check_segs("post_rst_segs", D1, D2);
    buzz = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
